// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, result codes and timing helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_e;

    localparam logic [1:0] TX_ERR_OK      = 2'd0;
    localparam logic [1:0] TX_ERR_NOACK   = 2'd1;
    localparam logic [1:0] TX_ERR_TIMEOUT = 2'd2;

    function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned us);
        return (freq_hz / 32'd1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchronisers for the PS/2 clock and data pins, plus a clock
// falling-edge strobe taken between the last synchroniser stage and one more flop.
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk_pin,
    input  logic ps2_data_pin,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [2:0] clk_sr_q, clk_sr_d;
    logic [2:0] data_sr_q, data_sr_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sr_d   = {clk_sr_q[1:0], ps2_clk_pin};
        data_sr_d  = {data_sr_q[1:0], ps2_data_pin};
        clk_prev_d = clk_sr_q[2];
    end

    // Idle bus level is high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sr_q   <= '1;
            data_sr_q  <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sr_q   <= clk_sr_d;
            data_sr_q  <= data_sr_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign clk_sync  = clk_sr_q[2];
    assign data_sync = data_sr_q[2];
    assign clk_fall  = clk_prev_q & ~clk_sr_q[2];

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: clock inhibit, request-to-send,
// device-clocked data/parity/stop, ack check, with a no-activity timeout.
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
    parameter int unsigned INHIBIT_US    = 120,
    parameter int unsigned RTS_SETUP_CYC = 16,
    parameter int unsigned TIMEOUT_US    = 20_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [1:0] tx_error,
    input  logic       ps2_clk_pin,
    input  logic       ps2_data_pin,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned TIMEOUT_CYC = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int unsigned CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX) + 1;

    logic clk_sync, data_sync, clk_fall;

    ps2_line_sync u_line_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_clk_pin  (ps2_clk_pin),
        .ps2_data_pin (ps2_data_pin),
        .clk_sync     (clk_sync),
        .data_sync    (data_sync),
        .clk_fall     (clk_fall)
    );

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ecnt_q, ecnt_d;
    logic [8:0]       sh_q, sh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             clk_low_q, clk_low_d;
    logic             data_low_q, data_low_d;
    logic             timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        ecnt_d     = ecnt_q;
        sh_d       = sh_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;

        unique case (state_q)
            IDLE: begin
                cnt_d      = '0;
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (tx_start) begin
                    sh_d      = {~^tx_data, tx_data};
                    err_d     = TX_ERR_OK;
                    busy_d    = 1'b1;
                    clk_low_d = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
                    cnt_d      = '0;
                    data_low_d = 1'b1;
                    state_d    = RTS;
                end
            end
            RTS: begin
                if (cnt_q == CNT_W'(RTS_SETUP_CYC - 1)) begin
                    cnt_d     = '0;
                    ecnt_d    = '0;
                    clk_low_d = 1'b0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    ecnt_d = ecnt_q + 4'd1;
                    if (ecnt_q == 4'd9) begin
                        data_low_d = 1'b0;
                        state_d    = ACK;
                    end else begin
                        data_low_d = ~sh_q[0];
                        sh_d       = {1'b0, sh_q[8:1]};
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    err_d   = data_sync ? TX_ERR_NOACK : TX_ERR_OK;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied after the case so the timeout wins over a same-cycle falling edge.
        if (timeout && (state_q inside {SEND, ACK, WAIT_IDLE})) begin
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            err_d      = TX_ERR_TIMEOUT;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ecnt_q     <= '0;
            sh_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= TX_ERR_OK;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ecnt_q     <= ecnt_d;
            sh_q       <= sh_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
        end
    end

    assign tx_busy            = busy_q;
    assign tx_done            = done_q;
    assign tx_error           = err_q;
    assign ps2_clk_drive_low  = clk_low_q;
    assign ps2_data_drive_low = data_low_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-drain bus with a behavioural PS/2 device.
module tb_ps2_host_transmitter;
    import ps2_pkg::*;

    localparam int unsigned INH = 100;
    localparam int unsigned RTSC = 16;
    localparam int unsigned TMO = 2000;
    localparam int H = 20;
    localparam int MODE_ACK = 0;
    localparam int MODE_NOACK = 1;
    localparam int MODE_SILENT = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done;
    logic [1:0] tx_error;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       cl, dl;

    assign cl = ~ps2_clk_drive_low & dev_clk;
    assign dl = ~ps2_data_drive_low & dev_dat;

    always #5 clk = ~clk;

    ps2_host_transmitter #(
        .CLK_FREQ_HZ   (1_000_000),
        .INHIBIT_US    (INH),
        .RTS_SETUP_CYC (RTSC),
        .TIMEOUT_US    (TMO)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tx_data            (tx_data),
        .tx_start           (tx_start),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .tx_error           (tx_error),
        .ps2_clk_pin        (cl),
        .ps2_data_pin       (dl),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always @(negedge clk) if (tx_done) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: wire bit sequence after each device falling edge 1..10.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2) == 0, d};
    endfunction

    function automatic logic [1:0] ref_err(input int mode);
        if (mode == MODE_ACK) return TX_ERR_OK;
        if (mode == MODE_NOACK) return TX_ERR_NOACK;
        return TX_ERR_TIMEOUT;
    endfunction

    // Behavioural device: reacts to request-to-send, clocks 11 pulses,
    // samples data on each rising edge, optionally acks.
    int         dev_mode = MODE_ACK;
    int         dev_edges = 0;
    bit         dev_got = 1'b0;
    bit         dev_active = 1'b0;
    bit         dev_abort = 1'b0;
    logic [9:0] dev_frame = '0;

    task automatic dev_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!reset_n) dev_abort = 1'b1;
        end
    endtask

    task automatic do_frame();
        dev_active = 1'b1;
        dev_abort  = 1'b0;
        dev_got    = 1'b0;
        dev_edges  = 0;
        dev_frame  = '0;
        dev_wait(H);
        for (int i = 1; i <= 11; i++) begin
            if (dev_abort) break;
            dev_clk   = 1'b0;
            dev_edges = i;
            dev_wait(H);
            dev_clk = 1'b1;
            if (dev_abort) break;
            if (i <= 10) dev_frame[i-1] = dl;
            if (i == 10 && dev_mode == MODE_ACK) begin
                dev_wait(H / 2);
                dev_dat = 1'b0;
                dev_wait(H - H / 2);
            end else begin
                dev_wait(H);
            end
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        if (!dev_abort) dev_got = 1'b1;
        dev_active = 1'b0;
    endtask

    initial begin : device
        logic prev_cl;
        prev_cl = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n && !prev_cl && cl && !dl && dev_mode != MODE_SILENT) do_frame();
            prev_cl = cl;
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while ((tx_busy || dev_active) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic run_tx(input logic [7:0] d, input int mode, input bit poke,
                          input logic [9:0] exp_frame, input logic [1:0] exp_err,
                          input string tag);
        int lat, rel, d0, guard;
        wait_idle();
        dev_mode = mode;
        d0 = done_cnt;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk({tag, "_busy_after_accept"}, tx_busy, 1'b1);
        lat = 1;
        while (ps2_clk_drive_low && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 5) begin
                tx_data  = 8'h55;
                tx_start = 1'b1;
            end
            if (poke && lat == 6) tx_start = 1'b0;
            if (lat == 50) chk({tag, "_inhibit_data_released"}, ps2_data_drive_low, 1'b0);
        end
        chk({tag, "_release_latency"}, lat, 1 + INH + RTSC);
        chk({tag, "_start_bit_held"}, ps2_data_drive_low, 1'b1);
        rel = 0;
        while (!tx_done && rel < 3000) begin
            @(negedge clk);
            rel++;
        end
        chk({tag, "_done_seen"}, tx_done, 1'b1);
        chk({tag, "_error"}, tx_error, exp_err);
        chk({tag, "_busy_at_done"}, tx_busy, 1'b0);
        chk({tag, "_lines_released"}, {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
        if (mode == MODE_SILENT) chk({tag, "_timeout_cycles"}, rel, TMO);
        guard = 0;
        while (dev_active && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_one_done_pulse"}, done_cnt - d0, 1);
        chk({tag, "_error_held"}, tx_error, exp_err);
        if (mode != MODE_SILENT) begin
            chk({tag, "_frame_captured"}, dev_got, 1'b1);
            chk({tag, "_frame_bits"}, dev_frame, exp_frame);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic [9:0] frame;
        logic [1:0] err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int guard, d0;
        logic [7:0] rd;
        int rm;

        vecs[0] = '{8'hED, MODE_ACK,   10'h3ED, TX_ERR_OK};
        vecs[1] = '{8'hF4, MODE_ACK,   10'h2F4, TX_ERR_OK};
        vecs[2] = '{8'h00, MODE_ACK,   10'h300, TX_ERR_OK};
        vecs[3] = '{8'hFF, MODE_NOACK, 10'h3FF, TX_ERR_NOACK};
        vecs[4] = '{8'h01, MODE_NOACK, 10'h201, TX_ERR_NOACK};

        reset_n  = 1'b0;
        tx_start = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_done", tx_done, 1'b0);
        chk("reset_error", tx_error, TX_ERR_OK);
        chk("reset_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_tx(vecs[i].data, vecs[i].mode, 1'b0, vecs[i].frame, vecs[i].err,
                   $sformatf("vec%0d", i));

        run_tx(8'hED, MODE_ACK, 1'b1, ref_frame(8'hED), TX_ERR_OK, "busy_poke");
        run_tx(8'hAA, MODE_SILENT, 1'b0, '0, TX_ERR_TIMEOUT, "timeout");

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(0, 255));
            rm = int'($urandom_range(0, 1));
            run_tx(rd, rm, 1'b0, ref_frame(rd), ref_err(rm), $sformatf("rand%0d", i));
        end

        // Reset mid-SEND after device edge 4 (D3 of 0xF4 is 0, so data is being pulled).
        wait_idle();
        dev_mode = MODE_ACK;
        d0 = done_cnt;
        @(negedge clk);
        tx_data  = 8'hF4;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        guard = 0;
        while (ps2_clk_drive_low && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        guard = 0;
        while (dev_edges < 4 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (6) @(negedge clk);
        chk("rst_pre_data_low", ps2_data_drive_low, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_lines_released", {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_frame_abandoned", dev_got, 1'b0);

        run_tx(8'hF4, MODE_ACK, 1'b0, ref_frame(8'hF4), TX_ERR_OK, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xF4 (enable), using the standard sequence: clock inhibit, request-to-send, device-clocked bits, ack check. It drives the open-drain PS/2 clock and data lines and sits beside the existing PS/2 receiver on the same pins. The receiver is gated by tx_busy so it ignores traffic the transmitter generates.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz.
INHIBIT_US, 120, time the clock is held low before request-to-send; INHIBIT_CYC = CLK_FREQ_HZ/1e6*INHIBIT_US.
RTS_SETUP_CYC, 16, cycles data is held low with clock still low before the clock is released.
TIMEOUT_US, 20000, limit from clock release to ack; TIMEOUT_CYC derived the same way as INHIBIT_CYC.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous reset, active low.
tx_data  in  8  byte to send; latched when tx_start is accepted.
tx_start  in  1  request strobe; accepted only when tx_busy=0.
tx_busy  out  1  high from acceptance until tx_done; also gates the receiver.
tx_done  out  1  one-cycle pulse when a transaction ends, whether it succeeded or failed.
tx_error  out  2  result code, valid at tx_done and held until the next accepted start: 0 = ok, 1 = no ack, 2 = timeout.
ps2_clk_pin  in  1  PS/2 clock line as read.
ps2_data_pin  in  1  PS/2 data line as read.
ps2_clk_drive_low  out  1  1 pulls the clock line low; 0 releases it (pad tristate).
ps2_data_drive_low  out  1  1 pulls the data line low; 0 releases it.

Behaviour:
- Input synchronisation: both pins pass through 3-flop synchronisers (reset value 1). A clock falling edge is sync_prev & ~sync.
- Reset values: tx_busy=0, tx_done=0, tx_error=0, both drive_low outputs=0 (lines released), state=IDLE. Reset asserted mid-transaction releases both lines immediately (asynchronous) and abandons the transaction without a tx_done pulse.
- Transmit shift register: sh[8:0] = {odd parity, tx_data}, with odd parity = ~^tx_data. Edge counter ecnt is 4 bits. Cycle counter is $clog2(max(INHIBIT_CYC, TIMEOUT_CYC)) + 1 bits.
- IDLE: both lines released.
  - tx_start with tx_busy=0: latch sh, set tx_error=0, tx_busy=1 on the next cycle, go to INHIBIT.
  - tx_start with tx_busy=1: ignored, no queuing.
- INHIBIT: clk_drive_low=1. After INHIBIT_CYC cycles, go to RTS.
- RTS: clk_drive_low=1 and data_drive_low=1 (start bit). After RTS_SETUP_CYC cycles, set clk_drive_low=0, clear the cycle counter and ecnt, go to SEND.
  - Falling edges caused by the host's own clock pull in INHIBIT/RTS are ignored.
- SEND: counts device falling edges; on falling edge n (ecnt becomes n):
  - n = 1..9: data_drive_low = ~sh[0], then sh shifts right. Data goes D0 first, then D7, then parity.
  - n = 10: data_drive_low=0 (stop bit, line released). Go to ACK.
- ACK: on the next falling edge, sample data_sync. 0 means ack is ok; 1 sets tx_error=1. Go to WAIT_IDLE either way.
- WAIT_IDLE: when clk_sync=1 and data_sync=1, pulse tx_done, drop tx_busy, go to IDLE.
- Timeout: in SEND, ACK or WAIT_IDLE, if the cycle counter reaches TIMEOUT_CYC:
  - release both lines, set tx_error=2, pulse tx_done, go to IDLE.
  - Timeout takes priority over a falling edge in the same cycle.
- Latency: tx_start accepted to clock release = 1 + INHIBIT_CYC + RTS_SETUP_CYC cycles. After the release, timing is set by the device.
- A falling edge seen in IDLE has no effect.
- tx_done and tx_start in the same cycle: the start is accepted, because tx_busy is already 0 in that cycle.

Decomposition:
- Package ps2_pkg:
  - tx state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE);
  - TX_ERR_OK/NOACK/TIMEOUT constants;
  - us_to_cycles() function.
- Sub-module ps2_line_sync: 3-flop synchroniser for clock and data plus falling-edge detect. It is shared with the receiver and instantiated once here.

Test Plan:
- Model: CLK_FREQ_HZ=100e6, INHIBIT_US=100, device model clocking at 12.5 kHz.
- Send 0xED: clock held low for 10000 cycles then released. Bits presented on edges 1..9 are 1,0,1,1,0,1,1,1 then parity 1. Data released on edge 10. Device acks. Expect tx_done with tx_error=0.
- Send 0xF4: data bits 0,0,1,0,1,1,1,1, parity 0. The device model checks the frame. Expect tx_error=0.
- Device never acks (data stays high on edge 11): expect tx_error=1 and one tx_done pulse, with both lines released.
- Device never clocks after release: tx_done arrives exactly 2,000,000 cycles after release with tx_error=2, both lines released, tx_busy=0.
- tx_start pulsed while tx_busy=1 with tx_data=0x55: ignored; the in-flight byte 0xED is sent unchanged.
- Assert reset_n during SEND after edge 4: both drive_low outputs are 0 within the same cycle, no tx_done, state IDLE. A following send of 0xF4 succeeds.
